// File: rtl/apu_pulse_bank_gen3.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apu_pulse_bank_gen3
//
// Bank of NUM_CH NES-style pulse channels for cartridge expansion audio.
// Each channel owns a duty sequencer (11-bit timer + 3-bit step), an envelope
// generator and a length counter. Channels are programmed over the CPU bus at
// BASE_ADDR + 4*c (reg0..reg3). A shared status register sits at
// BASE_ADDR + 4*NUM_CH. The per-channel 4-bit outputs are summed and registered
// into mix_out for the APU mixer.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset
//   apu_clk   one-clk enable at CPU/2 rate, advances the sequencer timers
//   e_pulse   frame-counter envelope strobe
//   l_pulse   frame-counter length strobe
//   a_in      CPU address
//   from_cpu  CPU write data
//   r_nw      1 = read, 0 = write (a write lands on every clk it is low)
//   to_cpu    status read data, zero when status is not being read
//   active    per-channel "length counter is non-zero"
//   mix_out   registered sum of all channel outputs
// -----------------------------------------------------------------------------
module apu_pulse_bank_gen3 #(
  parameter int          NUM_CH    = 2,
  parameter logic [15:0] BASE_ADDR = 16'h5000,
  parameter int          MIX_W     = 4 + $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apu_clk,
  input  logic              e_pulse,
  input  logic              l_pulse,
  input  logic [15:0]       a_in,
  input  logic [7:0]        from_cpu,
  input  logic              r_nw,
  output logic [7:0]        to_cpu,
  output logic [NUM_CH-1:0] active,
  output logic [MIX_W-1:0]  mix_out
);

  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'(4 * NUM_CH);

  // Channel programming registers
  logic [1:0]        duty_q   [NUM_CH];
  logic [1:0]        duty_d   [NUM_CH];
  logic [3:0]        vol_q    [NUM_CH];
  logic [3:0]        vol_d    [NUM_CH];
  logic [10:0]       period_q [NUM_CH];
  logic [10:0]       period_d [NUM_CH];
  logic [NUM_CH-1:0] halt_q, halt_d;
  logic [NUM_CH-1:0] cvol_q, cvol_d;
  logic [NUM_CH-1:0] enable_q, enable_d;

  // Sequencer, length and envelope state
  logic [10:0]       timer_q  [NUM_CH];
  logic [10:0]       timer_d  [NUM_CH];
  logic [2:0]        step_q   [NUM_CH];
  logic [2:0]        step_d   [NUM_CH];
  logic [7:0]        length_q [NUM_CH];
  logic [7:0]        length_d [NUM_CH];
  logic [3:0]        div_q    [NUM_CH];
  logic [3:0]        div_d    [NUM_CH];
  logic [3:0]        decay_q  [NUM_CH];
  logic [3:0]        decay_d  [NUM_CH];
  logic [NUM_CH-1:0] start_q, start_d;

  // Output path
  logic [3:0]        chan_out [NUM_CH];
  logic [MIX_W-1:0]  mix_q, mix_d;
  logic [7:0]        status_rd;

  // Bus decode
  logic [NUM_CH-1:0] wr_reg0, wr_reg2, wr_reg3;
  logic              wr_stat;
  logic              rd_stat;

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;
      5'd1:  v = 8'd254;
      5'd2:  v = 8'd20;
      5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;
      5'd5:  v = 8'd4;
      5'd6:  v = 8'd80;
      5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;
      5'd9:  v = 8'd8;
      5'd10: v = 8'd60;
      5'd11: v = 8'd10;
      5'd12: v = 8'd14;
      5'd13: v = 8'd12;
      5'd14: v = 8'd26;
      5'd15: v = 8'd14;
      5'd16: v = 8'd12;
      5'd17: v = 8'd16;
      5'd18: v = 8'd24;
      5'd19: v = 8'd18;
      5'd20: v = 8'd48;
      5'd21: v = 8'd20;
      5'd22: v = 8'd96;
      5'd23: v = 8'd22;
      5'd24: v = 8'd192;
      5'd25: v = 8'd24;
      5'd26: v = 8'd72;
      5'd27: v = 8'd26;
      5'd28: v = 8'd16;
      5'd29: v = 8'd28;
      5'd30: v = 8'd32;
      default: v = 8'd30;
    endcase
    return v;
  endfunction

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    case (duty)
      2'd0:    pat = 8'b0000_0001;
      2'd1:    pat = 8'b0000_0011;
      2'd2:    pat = 8'b0000_1111;
      default: pat = 8'b1111_1100;
    endcase
    return pat[step];
  endfunction

  // Address decode. BASE_ADDR is 4-aligned so each channel owns a full quad;
  // reg1 of every channel and the unused status-quad bytes decode to nothing.
  always_comb begin
    wr_reg0 = '0;
    wr_reg2 = '0;
    wr_reg3 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_reg0[c] = !r_nw && (a_in == BASE_ADDR + 16'(4 * c));
      wr_reg2[c] = !r_nw && (a_in == BASE_ADDR + 16'(4 * c + 2));
      wr_reg3[c] = !r_nw && (a_in == BASE_ADDR + 16'(4 * c + 3));
    end
    wr_stat = !r_nw && (a_in == STAT_ADDR);
    rd_stat =  r_nw && (a_in == STAT_ADDR);
  end

  // Next-state logic. Strobe-driven updates are computed from the current
  // state first; CPU writes are applied afterwards so that a write landing on
  // the same clk as a strobe overrides it (reg3 load beats l_pulse, status
  // disable beats l_pulse, reg3 step reset beats apu_clk), while the strobe
  // itself still sees the old register contents (e.g. e_pulse uses old V).
  always_comb begin
    enable_d = enable_q;
    if (wr_stat) begin
      enable_d = from_cpu[NUM_CH-1:0];
    end

    for (int c = 0; c < NUM_CH; c++) begin
      duty_d[c]   = duty_q[c];
      vol_d[c]    = vol_q[c];
      period_d[c] = period_q[c];
      halt_d[c]   = halt_q[c];
      cvol_d[c]   = cvol_q[c];
      timer_d[c]  = timer_q[c];
      step_d[c]   = step_q[c];
      length_d[c] = length_q[c];
      div_d[c]    = div_q[c];
      decay_d[c]  = decay_q[c];
      start_d[c]  = start_q[c];

      // Sequencer: the step counts downward, wrapping 0 -> 7.
      if (apu_clk) begin
        if (timer_q[c] == 11'd0) begin
          timer_d[c] = period_q[c];
          step_d[c]  = step_q[c] - 3'd1;
        end else begin
          timer_d[c] = timer_q[c] - 11'd1;
        end
      end

      if (l_pulse && (length_q[c] != 8'd0) && !halt_q[c]) begin
        length_d[c] = length_q[c] - 8'd1;
      end

      // Envelope: the halt bit doubles as the decay loop flag.
      if (e_pulse) begin
        if (start_q[c]) begin
          start_d[c] = 1'b0;
          decay_d[c] = 4'd15;
          div_d[c]   = vol_q[c];
        end else if (div_q[c] == 4'd0) begin
          div_d[c] = vol_q[c];
          if (decay_q[c] != 4'd0) begin
            decay_d[c] = decay_q[c] - 4'd1;
          end else if (halt_q[c]) begin
            decay_d[c] = 4'd15;
          end
        end else begin
          div_d[c] = div_q[c] - 4'd1;
        end
      end

      if (wr_reg0[c]) begin
        duty_d[c] = from_cpu[7:6];
        halt_d[c] = from_cpu[5];
        cvol_d[c] = from_cpu[4];
        vol_d[c]  = from_cpu[3:0];
      end

      if (wr_reg2[c]) begin
        period_d[c][7:0] = from_cpu;
      end

      // Note-on: the timer keeps running, only the step restarts.
      if (wr_reg3[c]) begin
        period_d[c][10:8] = from_cpu[2:0];
        start_d[c]        = 1'b1;
        step_d[c]         = 3'd0;
        if (enable_q[c]) begin
          length_d[c] = len_lut(from_cpu[7:3]);
        end
      end

      if (wr_stat && !from_cpu[c]) begin
        length_d[c] = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q   <= '0;
      cvol_q   <= '0;
      enable_q <= '0;
      start_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_q[c]   <= '0;
        vol_q[c]    <= '0;
        period_q[c] <= '0;
        timer_q[c]  <= '0;
        step_q[c]   <= '0;
        length_q[c] <= '0;
        div_q[c]    <= '0;
        decay_q[c]  <= '0;
      end
    end else begin
      halt_q   <= halt_d;
      cvol_q   <= cvol_d;
      enable_q <= enable_d;
      start_q  <= start_d;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_q[c]   <= duty_d[c];
        vol_q[c]    <= vol_d[c];
        period_q[c] <= period_d[c];
        timer_q[c]  <= timer_d[c];
        step_q[c]   <= step_d[c];
        length_q[c] <= length_d[c];
        div_q[c]    <= div_d[c];
        decay_q[c]  <= decay_d[c];
      end
    end
  end

  // Channel outputs and mix. Periods below 8 are muted (ultrasonic on the
  // original hardware). MIX_W holds 15*NUM_CH, so the sum never wraps.
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chan_out[c] = 4'd0;
      if ((length_q[c] != 8'd0) && (period_q[c] >= 11'd8) &&
          duty_bit(duty_q[c], step_q[c])) begin
        chan_out[c] = cvol_q[c] ? vol_q[c] : decay_q[c];
      end
      mix_d = mix_d + MIX_W'(chan_out[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix_out = mix_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      active[c] = (length_q[c] != 8'd0);
    end
  end

  always_comb begin
    status_rd = '0;
    status_rd[NUM_CH-1:0] = active;
    to_cpu = rd_stat ? status_rd : 8'h00;
  end

endmodule

// File: tb/tb_apu_pulse_bank_gen3.sv
`timescale 1ns/1ps
module tb_apu_pulse_bank_gen3;

  localparam int          N    = 2;
  localparam int          MW   = 4 + $clog2(N + 1);
  localparam logic [15:0] B    = 16'h5000;
  localparam logic [15:0] STAT = 16'h5008;

  logic          clk = 0;
  logic          rst = 0;
  logic          apu_clk = 0, e_pulse = 0, l_pulse = 0;
  logic [15:0]   a_in = 0;
  logic [7:0]    from_cpu = 0;
  logic          r_nw = 1;
  logic [7:0]    to_cpu;
  logic [N-1:0]  active;
  logic [MW-1:0] mix_out;

  // Second instance for the eight-channel configuration
  logic          apu8 = 0, e8 = 0, l8 = 0, rnw8 = 1;
  logic [15:0]   a8 = 0;
  logic [7:0]    d8 = 0;
  logic [7:0]    to8;
  logic [7:0]    act8;
  logic [7:0]    mix8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apu_pulse_bank_gen3 #(.NUM_CH(N), .BASE_ADDR(B)) dut (
    .clk(clk), .rst(rst), .apu_clk(apu_clk), .e_pulse(e_pulse), .l_pulse(l_pulse),
    .a_in(a_in), .from_cpu(from_cpu), .r_nw(r_nw),
    .to_cpu(to_cpu), .active(active), .mix_out(mix_out)
  );

  apu_pulse_bank_gen3 #(.NUM_CH(8), .BASE_ADDR(16'h5000)) dut8 (
    .clk(clk), .rst(rst), .apu_clk(apu8), .e_pulse(e8), .l_pulse(l8),
    .a_in(a8), .from_cpu(d8), .r_nw(rnw8),
    .to_cpu(to8), .active(act8), .mix_out(mix8)
  );

  // ---------------- behavioural reference model ----------------
  int LEN_TAB [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                       12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};
  int DUTY_TAB [4] = '{8'h01, 8'h03, 8'h0F, 8'hFC};

  int m_duty[N], m_halt[N], m_cv[N], m_vol[N], m_per[N], m_tmr[N], m_step[N];
  int m_len[N], m_start[N], m_div[N], m_dec[N], m_en[N];
  int m_mix;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_duty[i] = 0; m_halt[i] = 0; m_cv[i] = 0; m_vol[i] = 0; m_per[i] = 0;
      m_tmr[i] = 0; m_step[i] = 0; m_len[i] = 0; m_start[i] = 0; m_div[i] = 0;
      m_dec[i] = 0; m_en[i] = 0;
    end
    m_mix = 0;
  endtask

  function automatic int chan_level(int c);
    if (m_len[c] == 0 || m_per[c] < 8) return 0;
    if (((DUTY_TAB[m_duty[c]] >> m_step[c]) & 1) == 0) return 0;
    return (m_cv[c] != 0) ? m_vol[c] : m_dec[c];
  endfunction

  function automatic logic [N-1:0] exp_active();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_len[i] != 0);
    return v;
  endfunction

  function automatic logic [7:0] exp_status();
    logic [7:0] v;
    v = 8'h00;
    if (r_nw && a_in == STAT) v[N-1:0] = exp_active();
    return v;
  endfunction

  // Strobes act on the old state; a bus write then overwrites what it touches.
  task automatic model_update();
    int off, c, r;
    for (int i = 0; i < N; i++) begin
      if (apu_clk) begin
        if (m_tmr[i] == 0) begin
          m_tmr[i]  = m_per[i];
          m_step[i] = (m_step[i] + 7) % 8;
        end else m_tmr[i] = m_tmr[i] - 1;
      end
      if (l_pulse && m_len[i] > 0 && m_halt[i] == 0) m_len[i] = m_len[i] - 1;
      if (e_pulse) begin
        if (m_start[i] != 0) begin
          m_start[i] = 0; m_dec[i] = 15; m_div[i] = m_vol[i];
        end else if (m_div[i] == 0) begin
          m_div[i] = m_vol[i];
          if (m_dec[i] > 0) m_dec[i] = m_dec[i] - 1;
          else if (m_halt[i] != 0) m_dec[i] = 15;
        end else m_div[i] = m_div[i] - 1;
      end
    end
    if (!r_nw) begin
      off = int'(a_in) - int'(B);
      if (off == 4 * N) begin
        for (int i = 0; i < N; i++) begin
          m_en[i] = int'(from_cpu[i]);
          if (m_en[i] == 0) m_len[i] = 0;
        end
      end else if (off >= 0 && off < 4 * N) begin
        c = off / 4;
        r = off % 4;
        if (r == 0) begin
          m_duty[c] = int'(from_cpu[7:6]);
          m_halt[c] = int'(from_cpu[5]);
          m_cv[c]   = int'(from_cpu[4]);
          m_vol[c]  = int'(from_cpu[3:0]);
        end else if (r == 2) begin
          m_per[c] = (m_per[c] & 32'h700) | int'(from_cpu);
        end else if (r == 3) begin
          m_per[c] = (m_per[c] & 32'hFF) | (int'(from_cpu[2:0]) << 8);
          if (m_en[c] != 0) m_len[c] = LEN_TAB[from_cpu[7:3]];
          m_start[c] = 1;
          m_step[c]  = 0;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    int nmix;
    nmix = 0;
    for (int c = 0; c < N; c++) nmix += chan_level(c);
    @(posedge clk);
    model_update();
    m_mix = nmix;
    #1;
  endtask

  task automatic idle();
    r_nw = 1; a_in = 16'h0000; from_cpu = 8'h00;
    apu_clk = 0; e_pulse = 0; l_pulse = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    a_in = a; from_cpu = d; r_nw = 0;
    tick();
    r_nw = 1; a_in = 16'h0000; from_cpu = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; idle(); m_reset();
    repeat (3) @(posedge clk);
    #1;
    r_nw = 1; a_in = STAT; #1;
    n_checks++; if (to_cpu !== 8'h00) begin n_errors++; $display("FAIL reset_to_cpu got %h expected 00", to_cpu); end
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL reset_active got %b expected 00", active); end
    n_checks++; if (mix_out !== '0) begin n_errors++; $display("FAIL reset_mix got %0d expected 0", mix_out); end
    @(negedge clk); rst = 1;
    tick();
    n_checks++; if (to_cpu !== 8'h00) begin n_errors++; $display("FAIL post_reset_status got %h expected 00", to_cpu); end
    n_checks++; if (mix_out !== MW'(m_mix) || mix_out !== '0) begin n_errors++; $display("FAIL post_reset_mix got %0d expected 0", mix_out); end
    idle();
  endtask

  task automatic test_duty();
    int cnt15, cntbad;
    wr(STAT, 8'h01);
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL enable_no_load got %b expected 00", active); end
    wr(B + 16'd0, 8'hBF);
    wr(B + 16'd2, 8'h08);
    wr(B + 16'd3, 8'h08);
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL note_on_active got %b expected 01", active); end
    tick();
    n_checks++; if (mix_out !== MW'(15)) begin n_errors++; $display("FAIL note_on_mix got %0d expected 15", mix_out); end
    for (int i = 0; i < 200; i++) begin
      apu_clk = (i % 2 == 0);
      tick();
      n_checks++; if (mix_out !== MW'(m_mix)) begin n_errors++; $display("FAIL duty_model cyc %0d got %0d expected %0d", i, mix_out, m_mix); end
    end
    cnt15 = 0; cntbad = 0;
    for (int i = 0; i < 288; i++) begin
      apu_clk = (i % 2 == 0);
      tick();
      if (mix_out == MW'(15)) cnt15++;
      else if (mix_out != '0) cntbad++;
    end
    n_checks++; if (cnt15 != 144) begin n_errors++; $display("FAIL duty_high_count got %0d expected 144", cnt15); end
    n_checks++; if (cntbad != 0) begin n_errors++; $display("FAIL duty_levels got %0d odd samples expected 0", cntbad); end
    idle();
  endtask

  task automatic test_length();
    wr(B + 16'd0, 8'h10);
    wr(B + 16'd3, 8'h18);
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL len_load got %b expected 01", active); end
    l_pulse = 1; tick(); l_pulse = 0;
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL len_one_pulse got %b expected 01", active); end
    l_pulse = 1; tick(); l_pulse = 0;
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL len_expire got %b expected 00", active); end
    wr(B + 16'd0, 8'h30);
    wr(B + 16'd3, 8'h18);
    repeat (5) begin l_pulse = 1; tick(); l_pulse = 0; tick(); end
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL len_halt got %b expected 01", active); end
    idle();
  endtask

  task automatic test_envelope();
    int exp;
    wr(B + 16'd0, 8'h81);
    wr(B + 16'd2, 8'h10);
    wr(B + 16'd3, 8'h08);
    for (int k = 1; k <= 40; k++) begin
      e_pulse = 1; tick(); e_pulse = 0; tick();
      exp = 15 - (k - 1) / 2;
      if (exp < 0) exp = 0;
      n_checks++; if (mix_out !== MW'(exp)) begin n_errors++; $display("FAIL env_decay k=%0d got %0d expected %0d", k, mix_out, exp); end
    end
    wr(B + 16'd0, 8'hA1);
    wr(B + 16'd3, 8'h08);
    for (int k = 1; k <= 40; k++) begin
      e_pulse = 1; tick(); e_pulse = 0; tick();
      exp = ((15 - (k - 1) / 2) % 16 + 16) % 16;
      n_checks++; if (mix_out !== MW'(exp)) begin n_errors++; $display("FAIL env_loop k=%0d got %0d expected %0d", k, mix_out, exp); end
    end
    idle();
  endtask

  task automatic test_simultaneous();
    wr(B + 16'd0, 8'h10);
    l_pulse = 1; wr(B + 16'd3, 8'h08); l_pulse = 0;
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL sim_len_load got %b expected 01", active); end
    repeat (253) begin l_pulse = 1; tick(); end
    l_pulse = 0;
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL sim_len_254_hold got %b expected 01", active); end
    l_pulse = 1; tick(); l_pulse = 0;
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL sim_len_254_end got %b expected 00", active); end

    // reg3 together with e_pulse: start is consumed by the following e_pulse
    wr(B + 16'd0, 8'h81);
    e_pulse = 1; wr(B + 16'd3, 8'h08); e_pulse = 0;
    tick();
    n_checks++; if (mix_out !== MW'(m_mix)) begin n_errors++; $display("FAIL sim_env_model got %0d expected %0d", mix_out, m_mix); end
    e_pulse = 1; tick(); e_pulse = 0; tick();
    n_checks++; if (mix_out !== MW'(15)) begin n_errors++; $display("FAIL sim_env_start got %0d expected 15", mix_out); end

    // reg0 together with e_pulse: reload uses the old V (1), not the new (15)
    e_pulse = 1; tick(); e_pulse = 0;
    e_pulse = 1; wr(B + 16'd0, 8'h8F); e_pulse = 0;
    e_pulse = 1; tick(); e_pulse = 0;
    e_pulse = 1; tick(); e_pulse = 0; tick();
    n_checks++; if (mix_out !== MW'(13)) begin n_errors++; $display("FAIL sim_env_old_v got %0d expected 13", mix_out); end

    // status disable together with l_pulse
    wr(B + 16'd0, 8'hBF);
    wr(B + 16'd2, 8'h08);
    wr(B + 16'd3, 8'h08);
    tick();
    n_checks++; if (mix_out !== MW'(15)) begin n_errors++; $display("FAIL sim_audible got %0d expected 15", mix_out); end
    l_pulse = 1; wr(STAT, 8'h00); l_pulse = 0;
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL sim_disable got %b expected 00", active); end
    tick();
    n_checks++; if (mix_out !== '0) begin n_errors++; $display("FAIL sim_disable_mix got %0d expected 0", mix_out); end
    wr(STAT, 8'h01);
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL sim_enable_no_load got %b expected 00", active); end
    idle();
  endtask

  task automatic test_reset_mid();
    wr(B + 16'd3, 8'h08);
    for (int i = 0; i < 10; i++) begin apu_clk = (i % 2 == 0); tick(); end
    apu_clk = 0;
    #2 rst = 0;
    #1;
    m_reset();
    n_checks++; if (active !== 2'b00) begin n_errors++; $display("FAIL mid_reset_active got %b expected 00", active); end
    n_checks++; if (mix_out !== '0) begin n_errors++; $display("FAIL mid_reset_mix got %0d expected 0", mix_out); end
    r_nw = 1; a_in = STAT; #1;
    n_checks++; if (to_cpu !== 8'h00) begin n_errors++; $display("FAIL mid_reset_status got %h expected 00", to_cpu); end
    @(negedge clk); rst = 1; idle();
    wr(STAT, 8'h01);
    wr(B + 16'd0, 8'hBF);
    for (int i = 0; i < 20; i++) begin apu_clk = (i % 2 == 0); tick(); end
    apu_clk = 0;
    n_checks++; if (active !== 2'b00 || mix_out !== '0) begin n_errors++; $display("FAIL post_reset_silent got active %b mix %0d expected 00 and 0", active, mix_out); end
    wr(B + 16'd3, 8'h08);
    n_checks++; if (active !== 2'b01) begin n_errors++; $display("FAIL post_reset_retrigger got %b expected 01", active); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rv;
    int op, ch, rg;
    for (int i = 0; i < 800; i++) begin
      rv = $urandom;
      apu_clk = (i % 2 == 0);
      e_pulse = ($urandom % 12 == 0);
      l_pulse = ($urandom % 10 == 0);
      r_nw = 1; a_in = 16'h0000; from_cpu = 8'h00;
      op = $urandom % 10;
      if (op <= 3) begin
        ch = $urandom % N;
        rg = $urandom % 4;
        r_nw = 0;
        a_in = B + 16'(4 * ch + rg);
        if (rg == 3) from_cpu = {rv[4:0], rv[10:8] & 3'b001};
        else         from_cpu = rv[23:16];
      end else if (op == 4) begin
        r_nw = 0; a_in = STAT;
        from_cpu = (rv[2:0] == 3'd0) ? rv[15:8] : 8'h03;
      end else if (op == 5) begin
        a_in = STAT;
      end else begin
        r_nw = rv[20];
        a_in = B - 16'd2 + 16'(rv[4:0] % 14);
        from_cpu = rv[31:24];
      end
      #1;
      n_checks++; if (to_cpu !== exp_status()) begin n_errors++; $display("FAIL rand_to_cpu cyc %0d got %h expected %h", i, to_cpu, exp_status()); end
      tick();
      n_checks++; if (active !== exp_active()) begin n_errors++; $display("FAIL rand_active cyc %0d got %b expected %b", i, active, exp_active()); end
      n_checks++; if (mix_out !== MW'(m_mix)) begin n_errors++; $display("FAIL rand_mix cyc %0d got %0d expected %0d", i, mix_out, m_mix); end
    end
    idle();
  endtask

  task automatic test_eight_channels();
    int peak, odd;
    rnw8 = 0; a8 = 16'h5020; d8 = 8'hFF;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      a8 = 16'h5000 + 16'(4 * c);     d8 = 8'hFF; @(posedge clk); #1;
      a8 = 16'h5000 + 16'(4 * c + 2); d8 = 8'h08; @(posedge clk); #1;
      a8 = 16'h5000 + 16'(4 * c + 3); d8 = 8'h08; @(posedge clk); #1;
    end
    rnw8 = 1; a8 = 16'h5020; d8 = 8'h00; #1;
    n_checks++; if (act8 !== 8'hFF) begin n_errors++; $display("FAIL ch8_active got %h expected ff", act8); end
    n_checks++; if (to8 !== 8'hFF) begin n_errors++; $display("FAIL ch8_status got %h expected ff", to8); end
    peak = 0; odd = 0;
    for (int i = 0; i < 200; i++) begin
      apu8 = (i % 2 == 0);
      @(posedge clk); #1;
      if (int'(mix8) > peak) peak = int'(mix8);
      if (mix8 != 8'd0 && mix8 != 8'd120) odd++;
    end
    apu8 = 0;
    n_checks++; if (peak != 120) begin n_errors++; $display("FAIL ch8_peak got %0d expected 120", peak); end
    n_checks++; if (odd != 0) begin n_errors++; $display("FAIL ch8_levels got %0d odd samples expected 0", odd); end
    a8 = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_duty();
    test_length();
    test_envelope();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_eight_channels();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
